// File: rtl/stream_demux_1_4.sv
// One-to-four valid/ready stream demultiplexer.
// Each input beat is steered by in_sel into one of four single-entry output
// registers. Every channel keeps a wrapping count of beats it has delivered.
module stream_demux_1_4 #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [W-1:0]     out_data0,
    output logic [W-1:0]     out_data1,
    output logic [W-1:0]     out_data2,
    output logic [W-1:0]     out_data3,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam int unsigned NCH = 4;

    logic [NCH-1:0]   valid_q;
    logic [W-1:0]     data_q [NCH];
    logic [CNT_W-1:0] cnt_q  [NCH];

    logic             accept;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   drain;

    // Input handshake: ready when the selected slot is empty or emptying this
    // cycle. Combinational so a drain and a refill can share one cycle.
    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        load     = '0;
        drain    = '0;
        in_ready = ~rst & (~valid_q[in_sel] | out_ready[in_sel]);
        accept   = in_valid & in_ready;
        for (int i = 0; i < NCH; i++) begin
            load[i]  = accept & (in_sel == 2'(i));
            drain[i] = valid_q[i] & out_ready[i];
        end
    end

    // Per-channel slot and delivered-beat counter; a fill takes priority over
    // a drain so the slot stays full when both happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    data_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
                if (drain[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign cnt0      = cnt_q[0];
    assign cnt1      = cnt_q[1];
    assign cnt2      = cnt_q[2];
    assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: two instances (8-bit and 4-bit counters) share
// one stimulus stream and are compared against a cycle model and a
// per-channel delivery scoreboard.
module tb_stream_demux_1_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_ready;

    logic       in_ready_a, in_ready_b;
    logic [3:0] out_valid_a, out_valid_b;
    logic [7:0] da0, da1, da2, da3, db0, db1, db2, db3;
    logic [7:0] ca0, ca1, ca2, ca3;
    logic [3:0] cb0, cb1, cb2, cb3;

    logic [7:0] da [4];
    logic [7:0] db [4];
    logic [7:0] ca [4];
    logic [3:0] cb [4];

    assign da[0] = da0; assign da[1] = da1; assign da[2] = da2; assign da[3] = da3;
    assign db[0] = db0; assign db[1] = db1; assign db[2] = db2; assign db[3] = db3;
    assign ca[0] = ca0; assign ca[1] = ca1; assign ca[2] = ca2; assign ca[3] = ca3;
    assign cb[0] = cb0; assign cb[1] = cb1; assign cb[2] = cb2; assign cb[3] = cb3;

    always #5 clk = ~clk;

    stream_demux_1_4 #(.W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data0(da0), .out_data1(da1),
        .out_data2(da2), .out_data3(da3),
        .cnt0(ca0), .cnt1(ca1), .cnt2(ca2), .cnt3(ca3)
    );

    stream_demux_1_4 #(.W(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data0(db0), .out_data1(db1),
        .out_data2(db2), .out_data3(db3),
        .cnt0(cb0), .cnt1(cb1), .cnt2(cb2), .cnt3(cb3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Cycle model of the channel slots and counters.
    logic [3:0] mv;
    logic [7:0] md [4];
    logic [7:0] mc [4];
    logic       m_ready;

    assign m_ready = !rst && (!mv[in_sel] || out_ready[in_sel]);

    always @(posedge clk) begin
        if (rst) begin
            mv <= '0;
            for (int i = 0; i < 4; i++) begin
                md[i] <= '0;
                mc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mv[i] && out_ready[i]) mc[i] <= mc[i] + 8'd1;
                if (in_valid && m_ready && in_sel == 2'(i)) begin
                    mv[i] <= 1'b1;
                    md[i] <= in_data;
                end else if (out_ready[i]) begin
                    mv[i] <= 1'b0;
                end
            end
        end
    end

    // Scoreboard: accepted beats queued per channel, popped on delivery.
    logic [7:0] sbq [4][$];
    logic [7:0] sb_exp;
    bit         chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready_a), 32'(m_ready));
            check("in_ready_b", 32'(in_ready_b), 32'(m_ready));
            check("out_valid", 32'(out_valid_a), 32'(mv));
            check("out_valid_b", 32'(out_valid_b), 32'(mv));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("out_data%0d", i), 32'(da[i]), 32'(md[i]));
                check($sformatf("out_data%0d_b", i), 32'(db[i]), 32'(md[i]));
                check($sformatf("cnt%0d", i), 32'(ca[i]), 32'(mc[i]));
                check($sformatf("cnt%0d_b", i), 32'(cb[i]), 32'(mc[i][3:0]));
            end
            if (rst) begin
                for (int i = 0; i < 4; i++) sbq[i].delete();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (out_valid_a[i] && out_ready[i]) begin
                        check($sformatf("sb_pending%0d", i), 32'(sbq[i].size() != 0), 32'd1);
                        if (sbq[i].size() != 0) begin
                            sb_exp = sbq[i].pop_front();
                            check($sformatf("sb_data%0d", i), 32'(da[i]), 32'(sb_exp));
                        end
                    end
                end
                if (in_valid && m_ready) sbq[in_sel].push_back(in_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [1:0] s, input logic [7:0] d);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            #1;
            acc = m_ready;
            tick(1);
        end
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick(1);
        rst      = 1'b0;
    endtask

    initial begin
        logic [7:0] rd [4];
        rd[0] = 8'hA0; rd[1] = 8'hA1; rd[2] = 8'hA2; rd[3] = 8'hA3;

        // Reset with in_valid held high
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_sel = 2'd0; out_ready = 4'h0;
        tick(2);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_cnt%0d", i), 32'(ca[i]), 32'd0);
            check($sformatf("rst_data%0d", i), 32'(da[i]), 32'd0);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        chk_en   = 1'b1;

        // Routing: one beat per channel, back to back
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            send(2'(i), rd[i]);
            check("route_valid", 32'(out_valid_a), 32'(4'b0001 << i));
            check("route_data", 32'(da[i]), 32'(rd[i]));
        end
        in_valid = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) check($sformatf("route_cnt%0d", i), 32'(ca[i]), 32'd1);

        // Backpressure on channel 2
        out_ready = 4'b1011;
        send(2'd2, 8'h11);
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h22;
        #1;
        check("bp_in_ready", 32'(in_ready_a), 32'd0);
        tick(1);
        check("bp_hold_data", 32'(da[2]), 32'h11);
        check("bp_hold_valid", 32'(out_valid_a[2]), 32'd1);
        check("bp_in_ready2", 32'(in_ready_a), 32'd0);
        out_ready = 4'hF;
        #1;
        check("bp_release_ready", 32'(in_ready_a), 32'd1);
        tick(1);
        check("bp_new_data", 32'(da[2]), 32'h22);
        check("bp_new_valid", 32'(out_valid_a[2]), 32'd1);
        in_valid = 1'b0;
        tick(1);
        // one beat from routing plus the two here
        check("bp_cnt2", 32'(ca[2]), 32'd3);
        check("bp_drained", 32'(out_valid_a[2]), 32'd0);

        // Independence: channel 1 stalled, channel 3 flows
        out_ready = 4'b1101;
        send(2'd1, 8'h55);
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h66;
        #1;
        check("ind_in_ready", 32'(in_ready_a), 32'd1);
        tick(1);
        in_valid = 1'b0;
        check("ind_hold_data", 32'(da[1]), 32'h55);
        check("ind_hold_valid", 32'(out_valid_a[1]), 32'd1);
        check("ind_cnt1", 32'(ca[1]), 32'd1);
        check("ind_ch3_data", 32'(da[3]), 32'h66);
        check("ind_ch3_valid", 32'(out_valid_a[3]), 32'd1);
        out_ready = 4'hF;
        tick(2);

        // Throughput: 16 back-to-back beats on channel 0
        do_reset();
        out_ready = 4'hF;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(k);
            #1;
            check("thr_in_ready", 32'(in_ready_a), 32'd1);
            tick(1);
            check("thr_data", 32'(da[0]), 32'(k));
        end
        in_valid = 1'b0;
        tick(1);
        check("thr_cnt0", 32'(ca[0]), 32'd16);
        check("thr_cnt0_wrap4", 32'(cb[0]), 32'd0);

        // Counter wrap, then reset with a beat held and handshakes pending
        do_reset();
        out_ready = 4'hF;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h30 + 8'(k);
            tick(1);
        end
        in_valid = 1'b0;
        tick(1);
        check("wrap_cnt3_b", 32'(cb[3]), 32'd1);
        check("wrap_cnt3", 32'(ca[3]), 32'd17);
        out_ready = 4'h0;
        send(2'd0, 8'h77);
        in_valid = 1'b0;
        check("mid_hold_valid", 32'(out_valid_a[0]), 32'd1);
        check("mid_hold_data", 32'(da[0]), 32'h77);
        rst = 1'b1; out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h99;
        tick(1);
        check("mid_rst_valid", 32'(out_valid_a), 32'd0);
        check("mid_rst_valid_b", 32'(out_valid_b), 32'd0);
        check("mid_rst_ready", 32'(in_ready_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_rst_cnt%0d", i), 32'(ca[i]), 32'd0);
            check($sformatf("mid_rst_cnt%0d_b", i), 32'(cb[i]), 32'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) check($sformatf("sb_empty%0d", i), 32'(sbq[i].size()), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
